// File: rtl/cipher_stage_sequencer_if.sv
// Handshake and stage-control bundle for cipher_stage_sequencer.
// master = the sequencer, slave = upstream/downstream/stage environment.
interface cipher_stage_sequencer_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned OUT_W  = 17,
    parameter int unsigned KEY_W  = 5
);
    // Upstream requester
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              key_load;
    logic [KEY_W-1:0]  key_in;

    // Stage datapath control
    logic              stg_start;
    logic [DATA_W-1:0] stg_in_data;
    logic [KEY_W-1:0]  stg_key;
    logic              stg1_done;
    logic              stg2_done;
    logic [OUT_W-1:0]  stg2_out;
    logic              stg_clr;

    // Downstream consumer
    logic              out_valid;
    logic              out_ready;
    logic [OUT_W-1:0]  out_data;

    // Status
    logic              busy;
    logic [7:0]        blk_count;
    logic              err;

    modport master (
        input  in_valid, in_data, key_load, key_in,
        input  stg1_done, stg2_done, stg2_out,
        input  out_ready,
        output in_ready,
        output stg_start, stg_in_data, stg_key, stg_clr,
        output out_valid, out_data,
        output busy, blk_count, err
    );

    modport slave (
        output in_valid, in_data, key_load, key_in,
        output stg1_done, stg2_done, stg2_out,
        output out_ready,
        input  in_ready,
        input  stg_start, stg_in_data, stg_key, stg_clr,
        input  out_valid, out_data,
        input  busy, blk_count, err
    );
endinterface

// File: rtl/cipher_stage_sequencer.sv
// Sequences one block at a time through stage1 -> stage2, rotating the round key per block.
// Define STG_TIMEOUT_EN to add a per-stage watchdog that parks the sequencer in ERR.
module cipher_stage_sequencer #(
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned OUT_W       = 17,
    parameter int unsigned KEY_W       = 5,
    parameter int unsigned CLR_CYC     = 2,
    parameter int unsigned TIMEOUT_CYC = 64
) (
    input logic                      clk2,
    input logic                      rst,
    cipher_stage_sequencer_if.master bus
);

    localparam logic [2:0] StIdle  = 3'd0;
    localparam logic [2:0] StRun1  = 3'd1;
    localparam logic [2:0] StRun2  = 3'd2;
    localparam logic [2:0] StOut   = 3'd3;
    localparam logic [2:0] StClear = 3'd4;
    localparam logic [2:0] StErr   = 3'd5;

    localparam int unsigned        CLR_W    = (CLR_CYC > 1) ? $clog2(CLR_CYC) : 1;
    localparam logic [CLR_W-1:0]   CLR_LAST = CLR_W'(CLR_CYC - 1);

    if (CLR_CYC < 1 || KEY_W < 2 || OUT_W != DATA_W + 1 || TIMEOUT_CYC < 2) begin : g_bad_params
        $error("cipher_stage_sequencer: illegal parameter combination");
    end

    logic [2:0]        state_q, state_d;
    logic              start_q, start_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [KEY_W-1:0]  key_q, key_d;
    logic [OUT_W-1:0]  res_q, res_d;
    logic [7:0]        blk_q, blk_d;
    logic [CLR_W-1:0]  clr_cnt_q, clr_cnt_d;

    logic              err_w;
    logic              wd_expired;
    logic              in_ready_w;
    logic              accept;

    assign in_ready_w = (state_q == StIdle) && !err_w;
    assign accept     = bus.in_valid && in_ready_w;

    always_comb begin
        state_d   = state_q;
        start_d   = 1'b0;
        data_d    = data_q;
        key_d     = key_q;
        res_d     = res_q;
        blk_d     = blk_q;
        clr_cnt_d = clr_cnt_q;

        case (state_q)
            StIdle: begin
                // A key loaded alongside a block applies to that block.
                if (bus.key_load) begin
                    key_d = bus.key_in;
                end
                if (accept) begin
                    data_d  = bus.in_data;
                    start_d = 1'b1;
                    state_d = StRun1;
                end
            end
            StRun1: begin
                // stg2_done is deliberately not looked at here; RUN2 re-samples it.
                if (bus.stg1_done) begin
                    state_d = StRun2;
                end else if (wd_expired) begin
                    state_d = StErr;
                end
            end
            StRun2: begin
                if (bus.stg2_done) begin
                    res_d   = bus.stg2_out;
                    state_d = StOut;
                end else if (wd_expired) begin
                    state_d = StErr;
                end
            end
            StOut: begin
                if (bus.out_ready) begin
                    key_d     = {key_q[KEY_W-2:0], key_q[KEY_W-1]};
                    blk_d     = blk_q + 8'd1;
                    clr_cnt_d = '0;
                    state_d   = StClear;
                end
            end
            StClear: begin
                if (clr_cnt_q == CLR_LAST) begin
                    state_d = StIdle;
                end else begin
                    clr_cnt_d = clr_cnt_q + CLR_W'(1);
                end
            end
            StErr: begin
                state_d = StErr;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

`ifdef STG_TIMEOUT_EN
    localparam int unsigned      WD_W    = $clog2(TIMEOUT_CYC);
    localparam logic [WD_W-1:0]  WD_LAST = WD_W'(TIMEOUT_CYC - 1);

    logic [WD_W-1:0] wd_q, wd_d;
    logic            in_run;

    assign in_run     = (state_q == StRun1) || (state_q == StRun2);
    assign wd_expired = in_run && (wd_q == WD_LAST);

    // Restart on every state change so RUN1 and RUN2 each get a full budget.
    always_comb begin
        wd_d = wd_q;
        if (state_d != state_q) begin
            wd_d = '0;
        end else if (in_run) begin
            wd_d = wd_q + WD_W'(1);
        end
    end

    always_ff @(posedge clk2 or posedge rst) begin
        if (rst) begin
            wd_q <= '0;
        end else begin
            wd_q <= wd_d;
        end
    end

    assign err_w = (state_q == StErr);
`else
    assign wd_expired = 1'b0;
    assign err_w      = 1'b0;
`endif

    always_ff @(posedge clk2 or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            start_q   <= 1'b0;
            data_q    <= '0;
            key_q     <= '0;
            res_q     <= '0;
            blk_q     <= '0;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            start_q   <= start_d;
            data_q    <= data_d;
            key_q     <= key_d;
            res_q     <= res_d;
            blk_q     <= blk_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    assign bus.in_ready    = in_ready_w;
    assign bus.busy        = (state_q != StIdle);
    assign bus.stg_start   = start_q;
    assign bus.stg_in_data = data_q;
    assign bus.stg_key     = key_q;
    assign bus.stg_clr     = (state_q == StClear) || (state_q == StErr);
    assign bus.out_valid   = (state_q == StOut);
    assign bus.out_data    = res_q;
    assign bus.blk_count   = blk_q;
    assign bus.err         = err_w;

endmodule

// File: tb/tb_cipher_stage_sequencer.sv
// Randomized bench for cipher_stage_sequencer with a transaction-level reference model.
// Build with STG_TIMEOUT_EN defined to exercise the watchdog path.
module tb_cipher_stage_sequencer;

    localparam int unsigned DATA_W      = 16;
    localparam int unsigned OUT_W       = 17;
    localparam int unsigned KEY_W       = 5;
    localparam int unsigned CLR_CYC     = 2;
    localparam int unsigned TIMEOUT_CYC = 64;

    logic clk2 = 1'b0;
    logic rst;

    always #5 clk2 = ~clk2;

    cipher_stage_sequencer_if #(.DATA_W(DATA_W), .OUT_W(OUT_W), .KEY_W(KEY_W)) bus ();

    cipher_stage_sequencer #(
        .DATA_W      (DATA_W),
        .OUT_W       (OUT_W),
        .KEY_W       (KEY_W),
        .CLR_CYC     (CLR_CYC),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk2 (clk2),
        .rst  (rst),
        .bus  (bus)
    );

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference cipher applied by the modelled stage pair.
    function automatic logic [OUT_W-1:0] cipher(input logic [DATA_W-1:0] d,
                                                input logic [KEY_W-1:0] k);
        return {d ^ {k, k, k, k[0]}, ^d};
    endfunction

    function automatic logic [KEY_W-1:0] rotl(input logic [KEY_W-1:0] k);
        return {k[KEY_W-2:0], k[KEY_W-1]};
    endfunction

    // Stage model: sticky done flags some cycles after the start pulse; result is junk until done.
    int unsigned      stg_d1 = 0;
    int unsigned      stg_d2 = 0;
    int unsigned      stg_cnt;
    logic             stg_run;
    logic [OUT_W-1:0] junk;

    always @(posedge clk2) begin
        junk <= OUT_W'($urandom);
        if (rst || bus.stg_clr) begin
            stg_run       <= 1'b0;
            stg_cnt       <= 0;
            bus.stg1_done <= 1'b0;
            bus.stg2_done <= 1'b0;
        end else if (bus.stg_start) begin
            stg_run <= 1'b1;
            stg_cnt <= 1;
            if (stg_d1 == 0) bus.stg1_done <= 1'b1;
            if (stg_d2 == 0) bus.stg2_done <= 1'b1;
        end else if (stg_run) begin
            stg_cnt <= stg_cnt + 1;
            if (stg_cnt >= stg_d1) bus.stg1_done <= 1'b1;
            if (stg_cnt >= stg_d2) bus.stg2_done <= 1'b1;
        end
    end

    assign bus.stg2_out = bus.stg2_done ? cipher(bus.stg_in_data, bus.stg_key) : junk;

    logic [KEY_W-1:0] exp_key;
    logic [7:0]       exp_cnt;

    task automatic check_reset_outputs(input string tag);
        check({tag, ":in_ready"},    32'(bus.in_ready),    1);
        check({tag, ":busy"},        32'(bus.busy),        0);
        check({tag, ":err"},         32'(bus.err),         0);
        check({tag, ":stg_start"},   32'(bus.stg_start),   0);
        check({tag, ":stg_in_data"}, 32'(bus.stg_in_data), 0);
        check({tag, ":stg_key"},     32'(bus.stg_key),     0);
        check({tag, ":stg_clr"},     32'(bus.stg_clr),     0);
        check({tag, ":out_valid"},   32'(bus.out_valid),   0);
        check({tag, ":out_data"},    32'(bus.out_data),    0);
        check({tag, ":blk_count"},   32'(bus.blk_count),   0);
    endtask

    task automatic apply_reset();
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.key_load  = 1'b0;
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clk2);
        rst     = 1'b0;
        exp_key = '0;
        exp_cnt = '0;
        @(negedge clk2);
    endtask

    // Hand one block over without following it through.
    task automatic launch(input logic [DATA_W-1:0] data, input int unsigned d1,
                          input int unsigned d2);
        stg_d1       = d1;
        stg_d2       = d2;
        bus.in_valid = 1'b1;
        bus.in_data  = data;
        bus.key_load = 1'b0;
        @(negedge clk2);
        bus.in_valid = 1'b0;
    endtask

    // Full transaction: accept, stage wait, held output, clear.
    task automatic run_block(input logic [DATA_W-1:0] data, input logic kl,
                             input logic [KEY_W-1:0] key, input int unsigned d1,
                             input int unsigned d2, input int unsigned hold);
        int unsigned k;
        int unsigned t1;
        int unsigned t2;
        int unsigned t_out;
        int unsigned extra_start;
        int unsigned n_clr;
        int unsigned exp_out;

        k = 0;
        while (bus.in_ready !== 1'b1 && k < 50) begin
            @(negedge clk2);
            k++;
        end
        check("idle_ready", 32'(bus.in_ready), 1);
        check("idle_busy",  32'(bus.busy),     0);

        stg_d1       = d1;
        stg_d2       = d2;
        bus.in_valid = 1'b1;
        bus.in_data  = data;
        bus.key_load = kl;
        bus.key_in   = key;
        if (kl) exp_key = key;
        @(negedge clk2);

        check("start_pulse", 32'(bus.stg_start),   1);
        check("stg_in_data", 32'(bus.stg_in_data), 32'(data));
        check("stg_key",     32'(bus.stg_key),     32'(exp_key));
        check("run_ready",   32'(bus.in_ready),    0);
        check("run_busy",    32'(bus.busy),        1);

        t1 = 0;
        t2 = 0;
        t_out = 0;
        extra_start = 0;
        for (int c = 1; c <= 80; c++) begin
            if (c > 1) begin
                @(negedge clk2);
                if (bus.stg_start) extra_start++;
            end
            if (bus.out_valid === 1'b1) begin
                t_out = c;
                break;
            end
            if (t1 == 0 && bus.stg1_done) t1 = c;
            if (t2 == 0 && bus.stg2_done) t2 = c;
            // Upstream noise while busy must not reach the held block or key.
            bus.in_valid = 1'b0;
            bus.in_data  = DATA_W'($urandom);
            bus.key_in   = KEY_W'($urandom);
            bus.key_load = 1'($urandom_range(0, 1));
        end
        bus.key_load = 1'b0;
        exp_out = ((t1 + 1 > t2) ? t1 + 1 : t2) + 1;
        check("out_latency", t_out, exp_out);
        check("extra_start", extra_start, 0);

        for (int h = 0; h <= int'(hold); h++) begin
            if (h > 0) @(negedge clk2);
            check("out_valid",   32'(bus.out_valid),   1);
            check("out_data",    32'(bus.out_data),    32'(cipher(data, exp_key)));
            check("out_ready0",  32'(bus.in_ready),    0);
            check("out_nostart", 32'(bus.stg_start),   0);
            check("out_key",     32'(bus.stg_key),     32'(exp_key));
            check("out_blkdata", 32'(bus.stg_in_data), 32'(data));
        end
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b0;
        @(negedge clk2);
        bus.out_ready = 1'b0;

        exp_key = rotl(exp_key);
        exp_cnt = exp_cnt + 8'd1;
        check("clr_valid", 32'(bus.out_valid), 0);
        check("clr_busy",  32'(bus.busy),      1);
        check("clr_blk",   32'(bus.blk_count), 32'(exp_cnt));
        check("clr_key",   32'(bus.stg_key),   32'(exp_key));
        n_clr = 0;
        while (bus.stg_clr === 1'b1 && n_clr < 20) begin
            n_clr++;
            @(negedge clk2);
        end
        check("clr_len",     n_clr,                CLR_CYC);
        check("post_ready",  32'(bus.in_ready),    1);
        check("post_key",    32'(bus.stg_key),     32'(exp_key));
    endtask

    initial begin
        #900000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        logic [KEY_W-1:0] key0;

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.key_load  = 1'b0;
        bus.key_in    = '0;
        bus.out_ready = 1'b0;
        exp_key       = '0;
        exp_cnt       = '0;
        repeat (2) @(negedge clk2);
        check_reset_outputs("in_rst");
        rst = 1'b0;
        @(negedge clk2);
        check_reset_outputs("after_rst");

        // Basic block with a fresh key and instant stages.
        run_block(16'hA5A5, 1'b1, 5'b00101, 0, 0, 0);
        check("t1_key",   32'(bus.stg_key),   32'h0A);
        check("t1_count", 32'(bus.blk_count), 1);

        // Downstream stall.
        run_block(DATA_W'($urandom), 1'b0, '0, 1, 2, 10);

        // Both done flags rise together.
        run_block(DATA_W'($urandom), 1'b0, '0, 2, 2, 0);
        // stg2 done before stg1.
        run_block(DATA_W'($urandom), 1'b0, '0, 3, 0, 1);

        // 256 back-to-back blocks: counter wrap and 5-block key period.
        apply_reset();
        key0 = 5'b10011;
        for (int i = 0; i < 256; i++) begin
            run_block(DATA_W'($urandom), (i == 0), key0, $urandom_range(0, 4),
                      $urandom_range(0, 4), $urandom_range(0, 2));
            if ((i + 1) % 5 == 0) check("key_period", 32'(bus.stg_key), 32'(key0));
        end
        check("blk_wrap", 32'(bus.blk_count), 0);

        // Random blocks with occasional key loads.
        for (int i = 0; i < 20; i++) begin
            run_block(DATA_W'($urandom), ($urandom_range(0, 3) == 0), KEY_W'($urandom),
                      $urandom_range(0, 5), $urandom_range(0, 5), $urandom_range(0, 3));
        end

        // stg1 never finishes.
        launch(16'h0F0F, 100000, 100000);
`ifdef STG_TIMEOUT_EN
        for (int c = 1; c <= int'(TIMEOUT_CYC) + 1; c++) begin
            if (c > 1) @(negedge clk2);
            if (c == int'(TIMEOUT_CYC))     check("wd_err_early", 32'(bus.err), 0);
            if (c == int'(TIMEOUT_CYC) + 1) check("wd_err_set",   32'(bus.err), 1);
        end
        bus.in_valid = 1'b1;
        repeat (5) begin
            @(negedge clk2);
            check("err_sticky", 32'(bus.err),       1);
            check("err_clr",    32'(bus.stg_clr),   1);
            check("err_ready",  32'(bus.in_ready),  0);
            check("err_valid",  32'(bus.out_valid), 0);
        end
        bus.in_valid = 1'b0;
`else
        repeat (100) @(negedge clk2);
        check("nowd_err",   32'(bus.err),     0);
        check("nowd_busy",  32'(bus.busy),    1);
        check("nowd_clr",   32'(bus.stg_clr), 0);
        check("nowd_ready", 32'(bus.in_ready), 0);
`endif
        apply_reset();
        check_reset_outputs("post_stuck");

        // Async reset while waiting in RUN2.
        run_block(DATA_W'($urandom), 1'b1, 5'b11000, 0, 1, 0);
        launch(16'hBEEF, 0, 30);
        repeat (2) @(negedge clk2);
        check("pre_rst_busy", 32'(bus.busy), 1);
        rst = 1'b1;
        #1;
        check_reset_outputs("mid_rst");
        @(negedge clk2);
        rst     = 1'b0;
        exp_key = '0;
        exp_cnt = '0;
        @(negedge clk2);
        run_block(DATA_W'($urandom), 1'b0, '0, 1, 1, 0);
        check("rst_recover_cnt", 32'(bus.blk_count), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
